// File: rtl/seq_detector_param.sv
// Run-time configurable serial pattern detector with a registered match pulse and a saturating match counter.
// The reset configuration (pattern 1101, length 4, overlapping) matches the legacy fixed detector.
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1101),
    parameter int                 RST_LEN     = 4,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               sys_clk_i,
    input  logic               sys_rst_i,
    input  logic               in_valid_i,
    input  logic               in_i,
    input  logic               cfg_load_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               cfg_overlap_i,
    input  logic               cnt_clr_i,
    output logic               match_o,
    output logic [CNT_W-1:0]   match_cnt_o,
    output logic               armed_o
);

    localparam logic [LEN_W-1:0] MaxLenL = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] RstLenL = (RST_LEN > MAX_LEN) ? MaxLenL : LEN_W'(RST_LEN);

    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic [MAX_LEN-1:0] cfgPattern_q;
    logic [LEN_W-1:0]   cfgLen_q;
    logic               cfgOverlap_q;
    logic               hit_q;
    logic               match_q;
    logic [CNT_W-1:0]   matchCnt_q;

    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_d;
    logic [MAX_LEN-1:0] lenMask;
    logic               patternEq;
    logic               hit_d;
    logic [LEN_W-1:0]   loadLen;

    // Only the lowest cfgLen_q bits of the shifted history take part in the compare.
    always_comb begin
        hist_d    = {hist_q[MAX_LEN-2:0], in_i};
        fill_d    = (fill_q >= MaxLenL) ? MaxLenL : fill_q + LEN_W'(1);
        lenMask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            lenMask[i] = (i < int'(cfgLen_q));
        end
        patternEq = (((hist_d ^ cfgPattern_q) & lenMask) == '0);
        hit_d     = (cfgLen_q != '0) && (fill_d >= cfgLen_q) && patternEq;
        loadLen   = (cfg_len_i > MaxLenL) ? MaxLenL : cfg_len_i;
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            hist_q       <= '0;
            fill_q       <= '0;
            cfgPattern_q <= RST_PATTERN;
            cfgLen_q     <= RstLenL;
            cfgOverlap_q <= 1'b1;
            hit_q        <= 1'b0;
            match_q      <= 1'b0;
            matchCnt_q   <= '0;
        end else begin
            match_q <= hit_q;
            if (cnt_clr_i) begin
                matchCnt_q <= '0;
            end else if (match_q && (matchCnt_q != '1)) begin
                matchCnt_q <= matchCnt_q + CNT_W'(1);
            end
            // A load wipes history and any hit forming now; a hit already registered still becomes a pulse.
            if (cfg_load_i) begin
                cfgPattern_q <= cfg_pattern_i;
                cfgLen_q     <= loadLen;
                cfgOverlap_q <= cfg_overlap_i;
                hist_q       <= '0;
                fill_q       <= '0;
                hit_q        <= 1'b0;
            end else if (in_valid_i) begin
                hit_q  <= hit_d;
                hist_q <= hist_d;
                fill_q <= (!cfgOverlap_q && hit_d) ? '0 : fill_d;
            end else begin
                hit_q <= 1'b0;
            end
        end
    end

    assign match_o     = match_q;
    assign match_cnt_o = matchCnt_q;
    assign armed_o     = (cfgLen_q != '0) && (fill_q >= cfgLen_q);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a behavioural bit-queue model pushes expected outputs per edge,
// which are popped and compared after each edge, plus directed checks of key values.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 4;

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic               in_valid;
    logic               din;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               armed;

    typedef struct packed {
        logic             match;
        logic [CNT_W-1:0] cnt;
        logic             armed;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    int         mBits[$];
    logic [7:0] mPat;
    int         mLen;
    bit         mOv;
    bit         mHit;
    bit         mMatch;
    int         mCnt;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .sys_clk_i    (sys_clk),
        .sys_rst_i    (sys_rst),
        .in_valid_i   (in_valid),
        .in_i         (din),
        .cfg_load_i   (cfg_load),
        .cfg_pattern_i(cfg_pattern),
        .cfg_len_i    (cfg_len),
        .cfg_overlap_i(cfg_overlap),
        .cnt_clr_i    (cnt_clr),
        .match_o      (match),
        .match_cnt_o  (match_cnt),
        .armed_o      (armed)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: keeps the bits received since the last clear, newest at the back.
    task automatic modelEdge();
        int   nextCnt;
        bit   hit;
        exp_t e;
        if (sys_rst) begin
            mBits.delete();
            mPat = 8'b0000_1101; mLen = 4; mOv = 1'b1;
            mHit = 1'b0; mMatch = 1'b0; mCnt = 0;
        end else begin
            nextCnt = cnt_clr ? 0 : ((mMatch && mCnt < 255) ? mCnt + 1 : mCnt);
            mMatch  = mHit;
            if (cfg_load) begin
                mPat = cfg_pattern;
                mLen = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
                mOv  = cfg_overlap;
                mBits.delete();
                mHit = 1'b0;
            end else if (in_valid) begin
                mBits.push_back(int'(din));
                if (mBits.size() > MAX_LEN) void'(mBits.pop_front());
                hit = 1'b0;
                if (mLen != 0 && mBits.size() >= mLen) begin
                    hit = 1'b1;
                    for (int j = 0; j < mLen; j++)
                        if (mBits[mBits.size() - 1 - j] != int'(mPat[j])) hit = 1'b0;
                end
                mHit = hit;
                if (hit && !mOv) mBits.delete();
            end else begin
                mHit = 1'b0;
            end
            mCnt = nextCnt;
        end
        e.match = mMatch;
        e.cnt   = CNT_W'(mCnt);
        e.armed = (mLen != 0) && (mBits.size() >= mLen);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input bit rst, input bit valid, input bit b, input bit load, input bit clr,
                                 input logic [7:0] pat = 8'h00, input logic [3:0] len = 4'd0, input bit ov = 1'b1);
        exp_t e;
        @(negedge sys_clk);
        sys_rst = rst; in_valid = valid; din = b; cfg_load = load; cnt_clr = clr;
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
        modelEdge();
        @(posedge sys_clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = expQ.pop_front();
            checkOutput("sb_match", 32'(match), 32'(e.match));
            checkOutput("sb_cnt", 32'(match_cnt), 32'(e.cnt));
            checkOutput("sb_armed", 32'(armed), 32'(e.armed));
        end
    endtask

    task automatic feed(input bit b);
        applyStimulus(1'b0, 1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic feedBits(input logic [31:0] bits, input int n);
        logic [31:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) feed(v[i]);
    endtask

    task automatic loadCfg(input logic [7:0] pat, input logic [3:0] len, input bit ov, input bit clr, input bit b = 1'b0);
        applyStimulus(1'b0, 1'b1, b, 1'b1, clr, pat, len, ov);
    endtask

    initial begin
        sys_rst = 1'b1; in_valid = 1'b0; din = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b1; cnt_clr = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("reset_match", 32'(match), 32'd0);
        checkOutput("reset_cnt", 32'(match_cnt), 32'd0);
        checkOutput("reset_armed", 32'(armed), 32'd0);

        // Legacy 1101 overlapping behaviour.
        feedBits(32'b1101101, 7);
        idle(); idle();
        checkOutput("t1_cnt", 32'(match_cnt), 32'd2);

        // Non-overlapping mode: bits of a match are not reused.
        loadCfg(8'b0000_1101, 4'd4, 1'b0, 1'b1);
        feedBits(32'b1101101, 7);
        idle(); idle();
        checkOutput("t2_cnt", 32'(match_cnt), 32'd1);

        // Invalid cycles in the middle of a pattern change nothing.
        loadCfg(8'b0000_1101, 4'd4, 1'b1, 1'b1);
        feed(1'b1); feed(1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        feed(1'b0); feed(1'b1);
        checkOutput("t3_no_early", 32'(match), 32'd0);
        idle();
        checkOutput("t3_pulse", 32'(match), 32'd1);
        idle();
        checkOutput("t3_cnt", 32'(match_cnt), 32'd1);

        // Full-width pattern, then loads just after and exactly on the completing edge.
        loadCfg(8'b1010_1010, 4'd8, 1'b1, 1'b1);
        feedBits(32'b1010101010, 10);
        idle(); idle();
        checkOutput("t4_cnt", 32'(match_cnt), 32'd2);
        loadCfg(8'b1010_1010, 4'd8, 1'b1, 1'b1);
        feedBits(32'b10101010, 8);
        loadCfg(8'b1010_1010, 4'd8, 1'b1, 1'b0);
        checkOutput("t4_pending_pulse", 32'(match), 32'd1);
        idle(); idle();
        checkOutput("t4_pending_cnt", 32'(match_cnt), 32'd1);
        feedBits(32'b1010101, 7);
        loadCfg(8'b1010_1010, 4'd8, 1'b1, 1'b0, 1'b0);
        idle();
        checkOutput("t4_lost_pulse", 32'(match), 32'd0);
        idle();
        checkOutput("t4_lost_cnt", 32'(match_cnt), 32'd1);

        // Single-bit pattern: continuous matches, counter saturation, clear and reset mid-stream.
        loadCfg(8'b0000_0001, 4'd1, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            feed(1'b1);
            if (i == 1) checkOutput("t5_first_match", 32'(match), 32'd1);
        end
        checkOutput("t5_sat_cnt", 32'(match_cnt), 32'd255);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t5_clr_cnt", 32'(match_cnt), 32'd0);
        checkOutput("t5_clr_match", 32'(match), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_rst_match", 32'(match), 32'd0);
        feedBits(32'b1101, 4);
        idle(); idle();
        checkOutput("t5_rst_cfg_cnt", 32'(match_cnt), 32'd1);

        // Length 0 disables the detector even with an all-zero pattern.
        loadCfg(8'h00, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) feed(1'($urandom_range(0, 1)));
        idle(); idle();
        checkOutput("t6_len0_armed", 32'(armed), 32'd0);
        checkOutput("t6_len0_cnt", 32'(match_cnt), 32'd0);

        // Oversized length is clamped to the maximum.
        loadCfg(8'hFF, 4'd15, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) feed(1'b1);
        checkOutput("t6_clamp_not_armed", 32'(armed), 32'd0);
        feed(1'b1);
        checkOutput("t6_clamp_armed", 32'(armed), 32'd1);
        idle(); idle();
        checkOutput("t6_clamp_cnt", 32'(match_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
